// File: rtl/board_ram_ctrl.sv
// board_ram_ctrl
// Single-clock board memory controller holding an X_SIZE x Y_SIZE grid of
// DATA_WIDTH-bit cells. After reset, and whenever clear_req is seen in IDLE,
// a sweep writes every cell, one cell per cycle.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   clear_req, busy      clear sweep request (sampled in IDLE), sweep in progress
//   a_valid/a_ready      game-logic request handshake
//   a_we, a_x, a_y,      request type (1 = write), coordinates, write data
//   a_wdata
//   a_rvalid, a_rdata    read result strobe and data (valid one cycle, T+2)
//   a_err                out-of-range strobe for an accepted request
//   v_x, v_y             video coordinates, sampled every cycle
//   v_rdata, v_oob       video cell data and out-of-range flag (2-cycle latency)
//
// Configuration macro: BOARD_RAM_INIT_PATTERN_EN
//   When defined, sweeps write DATA_WIDTH'(x+y) into cell (x,y) instead of
//   CLEAR_VAL. Out-of-range reads and video reads during a sweep still
//   return CLEAR_VAL.
module board_ram_ctrl #(
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int CLEAR_VAL    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic                    a_we,
  input  logic [X_ADDR_WIDTH-1:0] a_x,
  input  logic [Y_ADDR_WIDTH-1:0] a_y,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic [X_ADDR_WIDTH-1:0] v_x,
  input  logic [Y_ADDR_WIDTH-1:0] v_y,
  output logic [DATA_WIDTH-1:0]   v_rdata,
  output logic                    v_oob
);

  localparam int CELLS = X_SIZE * Y_SIZE;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [DATA_WIDTH-1:0] CLEAR_D = DATA_WIDTH'(CLEAR_VAL);

  typedef enum logic [0:0] {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                  state;
  logic [AW-1:0]           sweep_addr;
  logic [DATA_WIDTH-1:0]   sweep_data;

  logic [DATA_WIDTH-1:0]   mem [CELLS];

  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Port A pipeline registers
  logic                    s1_valid;
  logic                    s1_we;
  logic                    s1_oob;
  logic [AW-1:0]           s1_addr;
  logic [DATA_WIDTH-1:0]   s1_wdata;
  logic                    s2_rvalid;
  logic                    s2_err;
  logic [DATA_WIDTH-1:0]   s2_rdata;

  // Video pipeline registers
  logic                    v1_oob;
  logic [AW-1:0]           v1_addr;

  logic                    accept;

  function automatic logic [AW-1:0] lin_addr(input logic [X_ADDR_WIDTH-1:0] x,
                                             input logic [Y_ADDR_WIDTH-1:0] y);
    return AW'(x) + AW'(y) * AW'(X_SIZE);
  endfunction

  function automatic logic is_oob(input logic [X_ADDR_WIDTH-1:0] x,
                                  input logic [Y_ADDR_WIDTH-1:0] y);
    return (int'(x) >= X_SIZE) || (int'(y) >= Y_SIZE);
  endfunction

  // A coincident clear request blocks acceptance so the sweep wins.
  assign a_ready = (state == S_IDLE) && !clear_req;
  assign accept  = a_valid && a_ready;

`ifdef BOARD_RAM_INIT_PATTERN_EN
  // Coordinate counters shadow sweep_addr so the pattern needs no divider.
  logic [X_ADDR_WIDTH-1:0] sweep_x;
  logic [Y_ADDR_WIDTH-1:0] sweep_y;

  assign sweep_data = DATA_WIDTH'(sweep_x) + DATA_WIDTH'(sweep_y);
`else
  assign sweep_data = CLEAR_D;
`endif

  // Sweep / idle controller. busy is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      busy       <= 1'b1;
      sweep_addr <= '0;
`ifdef BOARD_RAM_INIT_PATTERN_EN
      sweep_x    <= '0;
      sweep_y    <= '0;
`endif
    end else begin
      case (state)
        S_CLEAR: begin
          if (sweep_addr == AW'(CELLS - 1)) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            sweep_addr <= '0;
`ifdef BOARD_RAM_INIT_PATTERN_EN
            sweep_x    <= '0;
            sweep_y    <= '0;
`endif
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
`ifdef BOARD_RAM_INIT_PATTERN_EN
            if (sweep_x == X_ADDR_WIDTH'(X_SIZE - 1)) begin
              sweep_x <= '0;
              sweep_y <= sweep_y + 1'b1;
            end else begin
              sweep_x <= sweep_x + 1'b1;
            end
`endif
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            state      <= S_CLEAR;
            busy       <= 1'b1;
            sweep_addr <= '0;
`ifdef BOARD_RAM_INIT_PATTERN_EN
            sweep_x    <= '0;
            sweep_y    <= '0;
`endif
          end
        end
        default: begin
          state <= S_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Single write port. The sweep and port A never collide: the last write
  // that can be in flight commits on the edge that enters CLEAR, and the
  // sweep's first write is one edge later.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
      mem_wdata = sweep_data;
    end else if (s1_valid && s1_we && !s1_oob) begin
      mem_we    = 1'b1;
      mem_waddr = s1_addr;
      mem_wdata = s1_wdata;
    end
  end

  // Storage itself is never reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Port A: stage 1 captures the request, the memory is accessed on the
  // next edge (reads see any write committed one edge earlier), and the
  // result strobes are registered on the edge after that. a_rdata holds
  // the last read result between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_we     <= 1'b0;
      s1_oob    <= 1'b0;
      s1_addr   <= '0;
      s1_wdata  <= '0;
      s2_rvalid <= 1'b0;
      s2_err    <= 1'b0;
      s2_rdata  <= CLEAR_D;
      a_rvalid  <= 1'b0;
      a_err     <= 1'b0;
      a_rdata   <= CLEAR_D;
    end else begin
      s1_valid  <= accept;
      s1_we     <= a_we;
      s1_oob    <= is_oob(a_x, a_y);
      s1_addr   <= lin_addr(a_x, a_y);
      s1_wdata  <= a_wdata;
      s2_rvalid <= s1_valid && !s1_we;
      s2_err    <= s1_valid && s1_oob;
      s2_rdata  <= s1_oob ? CLEAR_D : mem[s1_addr];
      a_rvalid  <= s2_rvalid;
      a_err     <= s2_err;
      if (s2_rvalid) begin
        a_rdata <= s2_rdata;
      end
    end
  end

  // Video port: free-running two-stage lookup, masked while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_oob  <= 1'b0;
      v1_addr <= '0;
      v_oob   <= 1'b0;
      v_rdata <= CLEAR_D;
    end else begin
      v1_oob  <= is_oob(v_x, v_y);
      v1_addr <= lin_addr(v_x, v_y);
      v_oob   <= v1_oob;
      v_rdata <= (v1_oob || busy) ? CLEAR_D : mem[v1_addr];
    end
  end

endmodule

// File: tb/tb_board_ram_ctrl.sv
// tb_board_ram_ctrl
// Directed self-checking bench for board_ram_ctrl with default parameters
// (12x12 board, 2-bit cells, CLEAR_VAL 0). Expected cell contents come from
// a small board model that tracks sweeps and accepted in-range writes.
module tb_board_ram_ctrl;

  localparam int XS = 12;
  localparam int YS = 12;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          busy;
  logic          a_valid;
  logic          a_ready;
  logic          a_we;
  logic [XW-1:0] a_x;
  logic [YW-1:0] a_y;
  logic [DW-1:0] a_wdata;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          a_err;
  logic [XW-1:0] v_x;
  logic [YW-1:0] v_y;
  logic [DW-1:0] v_rdata;
  logic          v_oob;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [XS][YS];

  board_ram_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_we      (a_we),
    .a_x       (a_x),
    .a_y       (a_y),
    .a_wdata   (a_wdata),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .v_x       (v_x),
    .v_y       (v_y),
    .v_rdata   (v_rdata),
    .v_oob     (v_oob)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic we,
                                input int x, input int y,
                                input logic [DW-1:0] wd);
    a_valid = valid;
    a_we    = we;
    a_x     = XW'(x);
    a_y     = YW'(y);
    a_wdata = wd;
  endtask

  function automatic logic [DW-1:0] sweep_val(input int x, input int y);
`ifdef BOARD_RAM_INIT_PATTERN_EN
    return DW'(x + y);
`else
    return '0;
`endif
  endfunction

  task automatic init_model();
    for (int x = 0; x < XS; x++)
      for (int y = 0; y < YS; y++)
        model[x][y] = sweep_val(x, y);
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    int vx;

    rst_n     = 1'b0;
    clear_req = 1'b0;
    v_x       = '0;
    v_y       = '0;
    apply_stimulus(1'b0, 1'b0, 0, 0, '0);

    // Reset state
    step(); step(); step();
    check_output("rst_busy",    busy,     1);
    check_output("rst_ready",   a_ready,  0);
    check_output("rst_rvalid",  a_rvalid, 0);
    check_output("rst_rdata",   a_rdata,  0);
    check_output("rst_err",     a_err,    0);
    check_output("rst_vrdata",  v_rdata,  0);
    check_output("rst_voob",    v_oob,    0);

    // Power-up sweep length
    rst_n = 1'b1;
    wait_sweep(cnt);
    check_output("sweep0_len", cnt, 144);
    check_output("sweep0_ready", a_ready, 1);
    init_model();

    // Read (3,4) after the sweep
    apply_stimulus(1'b1, 1'b0, 3, 4, '0);
    step();
    a_valid = 1'b0;
    step();
    check_output("rd34_early", a_rvalid, 0);
    step();
    check_output("rd34_rvalid", a_rvalid, 1);
    check_output("rd34_rdata",  a_rdata,  model[3][4]);
    check_output("rd34_err",    a_err,    0);
    step();
    check_output("rd34_pulse", a_rvalid, 0);

    // Write (11,11)=3 then read it the very next cycle
    apply_stimulus(1'b1, 1'b1, 11, 11, 2'd3);
    step();
    model[11][11] = 2'd3;
    apply_stimulus(1'b1, 1'b0, 11, 11, '0);
    step();
    a_valid = 1'b0;
    check_output("raw_err1", a_err, 0);
    step();
    check_output("raw_err2",    a_err,    0);
    check_output("raw_wr_nrv",  a_rvalid, 0);
    step();
    check_output("raw_rvalid", a_rvalid, 1);
    check_output("raw_rdata",  a_rdata,  model[11][11]);
    check_output("raw_err3",   a_err,    0);

    // Out-of-range write (12,0)=2: dropped, a_err pulses at T+2
    apply_stimulus(1'b1, 1'b1, 12, 0, 2'd2);
    step();
    a_valid = 1'b0;
    step();
    check_output("oobw_err_early", a_err, 0);
    step();
    check_output("oobw_err",    a_err,    1);
    check_output("oobw_nrv",    a_rvalid, 0);
    step();
    check_output("oobw_errend", a_err,    0);

    // Cell (0,1) aliases linear address 12 and must be untouched
    apply_stimulus(1'b1, 1'b0, 0, 1, '0);
    step();
    a_valid = 1'b0;
    step(); step();
    check_output("alias_rvalid", a_rvalid, 1);
    check_output("alias_rdata",  a_rdata,  model[0][1]);

    // Out-of-range reads in x and in y
    apply_stimulus(1'b1, 1'b0, 12, 0, '0);
    step();
    apply_stimulus(1'b1, 1'b0, 0, 12, '0);
    step();
    a_valid = 1'b0;
    step();
    check_output("oobrx_rvalid", a_rvalid, 1);
    check_output("oobrx_rdata",  a_rdata,  0);
    check_output("oobrx_err",    a_err,    1);
    step();
    check_output("oobry_rvalid", a_rvalid, 1);
    check_output("oobry_rdata",  a_rdata,  0);
    check_output("oobry_err",    a_err,    1);

    // Video row scan after writing (4,2)=2, then x=13 out of range
    apply_stimulus(1'b1, 1'b1, 4, 2, 2'd2);
    step();
    a_valid = 1'b0;
    model[4][2] = 2'd2;
    step();
    v_y = YW'(2);
    for (int i = 0; i < 14; i++) begin
      vx  = (i < 12) ? i : 13;
      v_x = XW'(vx);
      step();
      if (i >= 1) begin
        vx = (i - 1 < 12) ? i - 1 : 13;
        check_output($sformatf("vid_x%0d_d", vx), v_rdata,
                     (vx < 12) ? model[vx][2] : 2'd0);
        check_output($sformatf("vid_x%0d_oob", vx), v_oob, (vx < 12) ? 0 : 1);
      end
    end

    // Write then read (7,7); clear_req arrives together with another request
    apply_stimulus(1'b1, 1'b1, 7, 7, 2'd1);
    step();
    apply_stimulus(1'b1, 1'b0, 7, 7, '0);
    step();
    apply_stimulus(1'b1, 1'b1, 5, 5, 2'd1);
    clear_req = 1'b1;
    #1;
    check_output("clr_ready", a_ready, 0);
    v_x = XW'(4);
    v_y = YW'(2);
    step();
    clear_req = 1'b0;
    a_valid   = 1'b0;
    check_output("clr_busy", busy, 1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      step();
      cnt++;
      if (cnt == 1) begin
        check_output("clr_inflight_rv", a_rvalid, 1);
        check_output("clr_inflight_rd", a_rdata,  1);
      end
      if (cnt == 5) begin
        check_output("clr_vid_masked", v_rdata, 0);
      end
    end
    check_output("clr_len", cnt, 144);
    init_model();

    // Back-to-back reads of every cell after the clear
    for (int n = 0; n < 146; n++) begin
      if (n < 144) apply_stimulus(1'b1, 1'b0, n % XS, n / XS, '0);
      else a_valid = 1'b0;
      step();
      if (n >= 2) begin
        check_output($sformatf("all_rv%0d", n - 2), a_rvalid, 1);
        check_output($sformatf("all_rd%0d", n - 2), a_rdata,
                     model[(n - 2) % XS][(n - 2) / XS]);
      end
    end
    a_valid = 1'b0;

    // Asynchronous reset while the sweep is at cell 50
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    v_x = XW'(13);
    for (int i = 0; i < 50; i++) step();
    check_output("mid_busy", busy, 1);
    check_output("mid_voob", v_oob, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_busy",   busy,     1);
    check_output("arst_ready",  a_ready,  0);
    check_output("arst_rvalid", a_rvalid, 0);
    check_output("arst_rdata",  a_rdata,  0);
    check_output("arst_err",    a_err,    0);
    check_output("arst_vrdata", v_rdata,  0);
    check_output("arst_voob",   v_oob,    0);
    #1;
    rst_n = 1'b1;
    v_x = XW'(0);
    wait_sweep(cnt);
    check_output("arst_len", cnt, 144);
    init_model();

    // A cell past the interrupted point reads its swept value
    apply_stimulus(1'b1, 1'b0, 10, 9, '0);
    step();
    a_valid = 1'b0;
    step(); step();
    check_output("final_rvalid", a_rvalid, 1);
    check_output("final_rdata",  a_rdata,  model[10][9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
